// File: rtl/risc16_pkg.sv
// Shared definitions for the 16-bit RISC control unit and datapath:
// widths, opcodes, instruction field positions and the sequencer state type.
package risc16_pkg;

    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int NREG = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_LI   = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_LW   = 4'hB;
    localparam logic [3:0] OP_SW   = 4'hC;
    localparam logic [3:0] OP_BEQ  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int IMM6_MSB = 5;
    localparam int IMM8_MSB = 7;
    localparam int TGT_MSB  = 3;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        HALT    = 2'd2
    } state_t;

    function automatic logic [DW-1:0] sext6(input logic [5:0] v);
        return {{(DW-6){v[5]}}, v};
    endfunction

endpackage

// File: rtl/risc16_control_datapath_if.sv
// Bring-up bus of the core: instruction-memory load port plus debug/status view.
interface risc16_control_datapath_if;
    import risc16_pkg::*;

    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic [2:0]    dbg_addr;
    logic [DW-1:0] dbg_data;
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          halted;

    modport master (
        output imem_we, imem_addr, imem_wdata, dbg_addr,
        input  dbg_data, pc, instr, halted
    );

    modport slave (
        input  imem_we, imem_addr, imem_wdata, dbg_addr,
        output dbg_data, pc, instr, halted
    );

endinterface

// File: rtl/risc16_alu.sv
// Combinational ALU; shift amounts use only the low 4 bits of b.
module risc16_alu
    import risc16_pkg::*;
(
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SLT: y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: y = a << b[3:0];
            OP_SRL: y = a >> b[3:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/risc16_control_datapath.sv
// Two-phase (FETCH/EXECUTE) 16-bit RISC core: sequencer, register file,
// ALU, 16-word instruction memory and 16-word data memory.
module risc16_control_datapath
    import risc16_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    risc16_control_datapath_if.slave   bus
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] imem [DEPTH];
    logic [DW-1:0] dmem [DEPTH];
    logic [DW-1:0] regs [NREG];

    state_t        state;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] instr_q;
    logic          halted_q;

    logic [3:0]    op;
    logic [2:0]    rd_idx, rs_idx, rt_idx;
    logic [5:0]    imm6;
    logic [7:0]    imm8;
    logic [DW-1:0] rd_val, rs_val, rt_val;

    assign op     = instr_q[OP_MSB:OP_LSB];
    assign rd_idx = instr_q[RD_MSB:RD_LSB];
    assign rs_idx = instr_q[RS_MSB:RS_LSB];
    assign rt_idx = instr_q[RT_MSB:RT_LSB];
    assign imm6   = instr_q[IMM6_MSB:0];
    assign imm8   = instr_q[IMM8_MSB:0];

    // r0 is masked on read so its storage never matters
    assign rd_val = (rd_idx == 3'd0) ? '0 : regs[rd_idx];
    assign rs_val = (rs_idx == 3'd0) ? '0 : regs[rs_idx];
    assign rt_val = (rt_idx == 3'd0) ? '0 : regs[rt_idx];

    logic [3:0]    alu_op;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_y;
    logic [AW-1:0] mem_addr;

    // ADDI/LW/SW share the ALU adder for rs + sext(imm6)
    always_comb begin
        alu_op = op;
        alu_b  = rt_val;
        if (op == OP_ADDI || op == OP_LW || op == OP_SW) begin
            alu_op = OP_ADD;
            alu_b  = sext6(imm6);
        end
    end

    risc16_alu u_alu (
        .op (alu_op),
        .a  (rs_val),
        .b  (alu_b),
        .y  (alu_y)
    );

    assign mem_addr = alu_y[AW-1:0];

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] next_pc;
    logic          wb_en;
    logic [DW-1:0] wb_data;

    assign pc_inc = pc_q + 1'b1;

    always_comb begin
        next_pc = pc_inc;
        case (op)
            OP_BEQ:  if (rd_val == rs_val) next_pc = pc_inc + imm6[AW-1:0];
            OP_JMP:  next_pc = instr_q[TGT_MSB:0];
            OP_HALT: next_pc = pc_q;
            default: next_pc = pc_inc;
        endcase
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_data = alu_y;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLT, OP_SLL, OP_SRL, OP_ADDI: wb_en = 1'b1;
            OP_LI: begin
                wb_en   = 1'b1;
                wb_data = {{(DW-8){1'b0}}, imm8};
            end
            OP_LW: begin
                wb_en   = 1'b1;
                wb_data = dmem[mem_addr];
            end
            default: wb_en = 1'b0;
        endcase
        if (rd_idx == 3'd0) wb_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc_q     <= '0;
            instr_q  <= '0;
            halted_q <= 1'b0;
            regs     <= '{default: '0};
            dmem     <= '{default: '0};
        end else begin
            case (state)
                FETCH: begin
                    instr_q <= imem[pc_q];
                    state   <= EXECUTE;
                end
                EXECUTE: begin
                    pc_q <= next_pc;
                    if (wb_en) regs[rd_idx] <= wb_data;
                    if (op == OP_SW) dmem[mem_addr] <= rd_val;
                    if (op == OP_HALT) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.dbg_data = (bus.dbg_addr == 3'd0) ? '0 : regs[bus.dbg_addr];
    assign bus.pc       = pc_q;
    assign bus.instr    = instr_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_risc16_control_datapath.sv
// Directed program vectors for the RISC16 core plus a mid-instruction reset sequence.
module tb_risc16_control_datapath;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    risc16_control_datapath_if bif ();

    risc16_control_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct packed {
        logic [15:0][15:0] prog;
        logic [3:0]        exp_pc;
        logic [2:0]        ra;
        logic [15:0]       va;
        logic [2:0]        rb;
        logic [15:0]       vb;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int n_vec  = 0;
    int n_fail = 0;

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input int imm);
        logic [31:0] t;
        t = imm;
        return {op, rd, rs, t[5:0]};
    endfunction

    function automatic logic [15:0] enc_li(input logic [2:0] rd, input logic [7:0] v);
        return {4'h9, rd, 1'b0, v};
    endfunction

    function automatic logic [15:0] enc_j(input logic [3:0] t);
        return {4'hE, 8'h00, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reg(input string name, input logic [2:0] r, input logic [15:0] exp);
        bif.dbg_addr = r;
        #1;
        check(name, bif.dbg_data, exp);
    endtask

    task automatic w(input int k, input int a, input logic [15:0] v);
        vecs[k].prog[a] = v;
    endtask

    task automatic ex(input int k, input logic [3:0] pc, input logic [2:0] ra,
                      input logic [15:0] va, input logic [2:0] rb, input logic [15:0] vb);
        vecs[k].exp_pc = pc;
        vecs[k].ra = ra; vecs[k].va = va;
        vecs[k].rb = rb; vecs[k].vb = vb;
    endtask

    task automatic run_until_halt(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (bif.halted) break;
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bif.imem_we = 1'b0;
        bif.imem_addr = '0;
        bif.imem_wdata = '0;
        bif.dbg_addr = '0;

        for (int k = 0; k < NV; k++) vecs[k].prog = {16{16'hF000}};

        w(0, 0, 16'h9205); w(0, 1, 16'hF000);
        ex(0, 4'd1, 3'd1, 16'h0005, 3'd0, 16'h0000);

        w(1, 0, enc_li(1, 8'hFF)); w(1, 1, enc_li(2, 8'h01)); w(1, 2, 16'h1650);
        ex(1, 4'd3, 3'd3, 16'h0100, 3'd1, 16'h00FF);

        w(2, 0, enc_li(1, 8'hFF)); w(2, 1, enc_li(2, 8'h01));
        w(2, 2, enc_r(4'h2, 4, 2, 1)); w(2, 3, enc_r(4'h6, 5, 4, 2));
        ex(2, 4'd4, 3'd4, 16'hFF02, 3'd5, 16'h0001);

        w(3, 0, enc_li(1, 8'hFF)); w(3, 1, enc_r(4'h1, 0, 1, 1));
        ex(3, 4'd2, 3'd0, 16'h0000, 3'd1, 16'h00FF);

        w(4, 0, enc_li(1, 8'h83)); w(4, 1, enc_li(2, 8'h10)); w(4, 2, enc_r(4'h7, 3, 1, 2));
        ex(4, 4'd3, 3'd3, 16'h0083, 3'd2, 16'h0010);

        w(5, 0, enc_li(1, 8'h83)); w(5, 1, enc_li(2, 8'h04));
        w(5, 2, enc_r(4'h7, 3, 1, 2)); w(5, 3, enc_r(4'h8, 4, 1, 2));
        ex(5, 4'd4, 3'd3, 16'h0830, 3'd4, 16'h0008);

        for (int k = 6; k <= 7; k++) begin
            w(k, 0, enc_li(1, 8'hCC)); w(k, 1, enc_li(2, 8'hAA));
            w(k, 2, enc_r(4'h3, 3, 1, 2)); w(k, 3, enc_r(4'h4, 4, 1, 2));
            w(k, 4, enc_r(4'h5, 5, 1, 2));
        end
        ex(6, 4'd5, 3'd4, 16'h00EE, 3'd5, 16'h0066);
        ex(7, 4'd5, 3'd3, 16'h0088, 3'd1, 16'h00CC);

        w(8, 0, enc_li(1, 8'hAB)); w(8, 1, 16'hC203); w(8, 2, enc_i(4'hB, 6, 0, 3));
        ex(8, 4'd3, 3'd6, 16'h00AB, 3'd1, 16'h00AB);

        w(9, 0, enc_li(1, 8'h5A)); w(9, 1, enc_i(4'hC, 1, 0, -1));
        w(9, 2, enc_i(4'hB, 2, 0, 15)); w(9, 3, enc_i(4'hA, 3, 0, -1));
        ex(9, 4'd4, 3'd2, 16'h005A, 3'd3, 16'hFFFF);

        w(10, 0, enc_li(1, 8'h0A)); w(10, 1, enc_i(4'hA, 2, 1, -3));
        w(10, 2, enc_i(4'hA, 3, 2, 31));
        ex(10, 4'd3, 3'd2, 16'h0007, 3'd3, 16'h0026);

        w(11, 0, enc_li(2, 8'h01)); w(11, 1, enc_i(4'hA, 1, 1, 1));
        w(11, 2, enc_i(4'hD, 1, 2, -2));
        ex(11, 4'd3, 3'd1, 16'h0002, 3'd2, 16'h0001);

        for (int k = 12; k <= 13; k++) begin
            w(k, 0, enc_i(4'hA, 1, 1, 1)); w(k, 1, enc_li(2, 8'h02));
            w(k, 2, enc_i(4'hD, 1, 2, 1));
        end
        w(12, 3, enc_j(4'd15)); w(12, 15, enc_j(4'd0));
        ex(12, 4'd4, 3'd1, 16'h0002, 3'd2, 16'h0002);
        w(13, 3, enc_j(4'd14)); w(13, 14, 16'h0000); w(13, 15, 16'h0000);
        ex(13, 4'd4, 3'd1, 16'h0002, 3'd2, 16'h0002);

        w(14, 0, enc_li(3, 8'h77)); w(14, 1, enc_i(4'hB, 3, 0, 3));
        ex(14, 4'd2, 3'd3, 16'h0000, 3'd0, 16'h0000);

        // Reset state
        step(); step();
        check("rst.pc", {12'h000, bif.pc}, 16'h0000);
        check("rst.instr", bif.instr, 16'h0000);
        check("rst.halted", {15'h0, bif.halted}, 16'h0000);
        check_reg("rst.r7", 3'd7, 16'h0000);

        for (int k = 0; k < NV; k++) begin
            reset = 1'b1;
            for (int a = 0; a < 16; a++) begin
                bif.imem_we = 1'b1;
                bif.imem_addr = 4'(a);
                bif.imem_wdata = vecs[k].prog[a];
                step();
            end
            bif.imem_we = 1'b0;
            step();
            reset = 1'b0;
            run_until_halt(200);
            check($sformatf("v%0d.halted", k), {15'h0, bif.halted}, 16'h0001);
            repeat (4) step();
            check($sformatf("v%0d.pc", k), {12'h000, bif.pc}, {12'h000, vecs[k].exp_pc});
            check_reg($sformatf("v%0d.r%0d", k, vecs[k].ra), vecs[k].ra, vecs[k].va);
            check_reg($sformatf("v%0d.r%0d", k, vecs[k].rb), vecs[k].rb, vecs[k].vb);
        end

        // Reset during EXECUTE of a store: the store must not land
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bif.imem_we = 1'b1;
            bif.imem_addr = 4'(a);
            case (a)
                0: bif.imem_wdata = enc_li(1, 8'hAB);
                1: bif.imem_wdata = 16'hC203;
                2: bif.imem_wdata = enc_i(4'hB, 6, 0, 3);
                default: bif.imem_wdata = 16'hF000;
            endcase
            step();
        end
        bif.imem_we = 1'b0;
        step();
        reset = 1'b0;
        step(); step(); step();
        check("mid.instr_sw", bif.instr, 16'hC203);
        check_reg("mid.r1_before", 3'd1, 16'h00AB);
        reset = 1'b1;
        bif.imem_we = 1'b1; bif.imem_addr = 4'd1; bif.imem_wdata = enc_i(4'hB, 6, 0, 3);
        step();
        bif.imem_addr = 4'd2; bif.imem_wdata = 16'hF000;
        step();
        bif.imem_we = 1'b0;
        reset = 1'b0;
        check("mid.pc", {12'h000, bif.pc}, 16'h0000);
        check("mid.instr", bif.instr, 16'h0000);
        check("mid.halted", {15'h0, bif.halted}, 16'h0000);
        check_reg("mid.r1", 3'd1, 16'h0000);
        step();
        check("mid.fetch", bif.instr, 16'h92AB);
        run_until_halt(100);
        check("mid.halt", {15'h0, bif.halted}, 16'h0001);
        check("mid.end_pc", {12'h000, bif.pc}, 16'h0002);
        check_reg("mid.r6", 3'd6, 16'h0000);
        check_reg("mid.r1_after", 3'd1, 16'h00AB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
